// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch-conditioning logic.
// The clock rate and debounce time together set the default debounce length.
package board_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int NUM_SW          = 10;

endpackage

// File: rtl/debounce_bit.sv
// Debounces one switch bit: a 2-FF synchroniser, a stability counter and the accepted level.
// The upd flag is combinational and is high during the cycle in which the clock edge flips clean.
module debounce_bit import board_pkg::*; #(
  parameter int CNT_MAX = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic clean,
  output logic upd
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign upd = (sync2 != clean) && (cnt == CNT_LAST);

  // Any cycle of agreement restarts the count, so short bounces never reach clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (upd) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the slide switches, with a one-cycle change strobe.
// Define SWITCH_DEBOUNCER_EDGE_EN to add per-bit sw_rise / sw_fall pulses.
module switch_debouncer import board_pkg::*; #(
  parameter int N       = NUM_SW,
  parameter int CNT_MAX = DEBOUNCE_CYCLES
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic [N-1:0] SW,
  output logic [N-1:0] SW_clean,
  output logic         sw_changed
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  ,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall
`endif
);

  logic [N-1:0] upd;

  for (genvar g = 0; g < N; g++) begin : g_bit
    debounce_bit #(
      .CNT_MAX(CNT_MAX)
    ) u_bit (
      .clk  (CLOCK_50),
      .rst_n(resetn),
      .d    (SW[g]),
      .clean(SW_clean[g]),
      .upd  (upd[g])
    );
  end

  // Strobes are registered from the same edge that updates SW_clean, so they line up.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |upd;
    end
  end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= upd & ~SW_clean;
      sw_fall <= upd & SW_clean;
    end
  end
`endif

endmodule
